// File: rtl/modn_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// modn_sweep_ctrl
//
// Sweeps a modulo-N counter through L complete 0..N-1 wraps, then emits a
// one-cycle done pulse. N and L are captured when a start is accepted in
// IDLE, so later changes on modulus/loops do not disturb a running sweep.
//
// Optional feature (compile-time macro): MODN_SWEEP_PAUSE_EN
//   When defined, a 'pause' input and a PAUSE state are added. Pause holds
//   the count and loop counter; stop still aborts from PAUSE.
//
// Ports
//   clk      in   rising-edge clock
//   reset    in   asynchronous active-low reset
//   start    in   begin a sweep (sampled only in IDLE)
//   modulus  in   [WIDTH-1:0]  modulus N, latched on accepted start
//   loops    in   [LWIDTH-1:0] wrap count L, latched on accepted start
//   stop     in   abort the sweep (RUN/PAUSE only), no done pulse
//   pause    in   hold counting (only with MODN_SWEEP_PAUSE_EN)
//   d_out    out  [WIDTH-1:0]  current count
//   tc       out  terminal count: count is N-1 and advancing this cycle
//   loop_cnt out  [LWIDTH-1:0] completed wraps in the current sweep
//   busy     out  high in RUN (and PAUSE)
//   done     out  one-cycle pulse on normal completion
// ---------------------------------------------------------------------------
module modn_sweep_ctrl #(
    parameter int WIDTH  = 3,
    parameter int LWIDTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [WIDTH-1:0]  modulus,
    input  logic [LWIDTH-1:0] loops,
    input  logic              stop,
`ifdef MODN_SWEEP_PAUSE_EN
    input  logic              pause,
`endif
    output logic [WIDTH-1:0]  d_out,
    output logic              tc,
    output logic [LWIDTH-1:0] loop_cnt,
    output logic              busy,
    output logic              done
);

`ifdef MODN_SWEEP_PAUSE_EN
    typedef enum logic [1:0] {IDLE, RUN, DONE, PAUSE} state_t;
`else
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
`endif

    state_t            state_reg, state_next;
    logic [WIDTH-1:0]  count_reg, count_next;
    logic [LWIDTH-1:0] loop_reg,  loop_next;
    logic [WIDTH-1:0]  mod_reg,   mod_next;
    logic [LWIDTH-1:0] lps_reg,   lps_next;

    logic [WIDTH-1:0]  top_val;
    logic [LWIDTH-1:0] last_loop;
    logic              at_top;
    logic              hold;

    // N and L are non-zero whenever RUN is entered, so these never wrap
    // while they matter.
    assign top_val   = mod_reg - 1'b1;
    assign last_loop = lps_reg - 1'b1;
    assign at_top    = (count_reg == top_val);

`ifdef MODN_SWEEP_PAUSE_EN
    // A pause request in RUN freezes the count on that very edge, so the
    // cycle is not an advancing one and must not flag terminal count.
    assign hold = pause;
`else
    assign hold = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
            count_reg <= '0;
            loop_reg  <= '0;
            mod_reg   <= '0;
            lps_reg   <= '0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
            loop_reg  <= loop_next;
            mod_reg   <= mod_next;
            lps_reg   <= lps_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        loop_next  = loop_reg;
        mod_next   = mod_reg;
        lps_next   = lps_reg;

        case (state_reg)
            IDLE: begin
                count_next = '0;
                loop_next  = '0;
                // stop is ignored here; start wins even if both are high
                if (start) begin
                    mod_next = modulus;
                    lps_next = loops;
                    if (modulus == '0 || loops == '0)
                        state_next = DONE;
                    else
                        state_next = RUN;
                end
            end

            RUN: begin
                // stop takes priority over a coincident final wrap
                if (stop) begin
                    state_next = IDLE;
                    count_next = '0;
                    loop_next  = '0;
                end
`ifdef MODN_SWEEP_PAUSE_EN
                else if (pause) begin
                    state_next = PAUSE;
                end
`endif
                else if (at_top) begin
                    count_next = '0;
                    loop_next  = loop_reg + 1'b1;
                    if (loop_reg == last_loop)
                        state_next = DONE;
                end else begin
                    count_next = count_reg + 1'b1;
                end
            end

`ifdef MODN_SWEEP_PAUSE_EN
            PAUSE: begin
                if (stop) begin
                    state_next = IDLE;
                    count_next = '0;
                    loop_next  = '0;
                end else if (!pause) begin
                    state_next = RUN;
                end
            end
`endif

            DONE: begin
                // loop_cnt stays at L for the done cycle, clears in IDLE
                state_next = IDLE;
                count_next = '0;
                loop_next  = '0;
            end

            default: begin
                state_next = IDLE;
                count_next = '0;
                loop_next  = '0;
            end
        endcase
    end

    assign d_out    = count_reg;
    assign loop_cnt = loop_reg;
    assign done     = (state_reg == DONE);
`ifdef MODN_SWEEP_PAUSE_EN
    assign busy     = (state_reg == RUN) || (state_reg == PAUSE);
`else
    assign busy     = (state_reg == RUN);
`endif
    assign tc       = (state_reg == RUN) && at_top && !hold;

endmodule

// File: tb/tb_modn_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// tb_modn_sweep_ctrl
//
// Directed bench for modn_sweep_ctrl (default build, WIDTH=3, LWIDTH=4).
// Inputs are driven and outputs sampled on the falling clock edge, well away
// from the rising edge where the DUT updates. Expected values come from the
// simple arithmetic of the count sequence (i mod N, i div N).
// ---------------------------------------------------------------------------
module tb_modn_sweep_ctrl;

    logic       clk;
    logic       reset;
    logic       start;
    logic [2:0] modulus;
    logic [3:0] loops;
    logic       stop;
    logic [2:0] d_out;
    logic       tc;
    logic [3:0] loop_cnt;
    logic       busy;
    logic       done;
`ifdef MODN_SWEEP_PAUSE_EN
    logic       pause;
    initial pause = 1'b0;
`endif

    int n_checks;
    int n_fail;

    modn_sweep_ctrl #(.WIDTH(3), .LWIDTH(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .modulus  (modulus),
        .loops    (loops),
        .stop     (stop),
`ifdef MODN_SWEEP_PAUSE_EN
        .pause    (pause),
`endif
        .d_out    (d_out),
        .tc       (tc),
        .loop_cnt (loop_cnt),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input int e_d, input int e_tc,
                             input int e_loop, input int e_busy, input int e_done);
        check({tag, ".d_out"},    int'(d_out),    e_d);
        check({tag, ".tc"},       int'(tc),       e_tc);
        check({tag, ".loop_cnt"}, int'(loop_cnt), e_loop);
        check({tag, ".busy"},     int'(busy),     e_busy);
        check({tag, ".done"},     int'(done),     e_done);
    endtask

    // Called at a falling edge; returns at a falling edge in IDLE.
    // Also pokes start and new modulus/loops mid-sweep; they must be ignored.
    task automatic sweep(input string tag, input int n, input int l);
        start   = 1'b1;
        modulus = 3'(n);
        loops   = 4'(l);
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < n * l; i++) begin
            check_all($sformatf("%s[%0d]", tag, i), i % n,
                      ((i % n) == n - 1) ? 1 : 0, i / n, 1, 0);
            if (i == 1) begin
                start   = 1'b1;
                modulus = 3'd2;
                loops   = 4'd1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        check_all({tag, ".done"}, 0, 0, l, 0, 1);
        @(negedge clk);
        check_all({tag, ".idle"}, 0, 0, 0, 0, 0);
        $display("sweep %s N=%0d L=%0d complete", tag, n, l);
    endtask

    // N=0 or L=0: straight to DONE with no busy cycle.
    task automatic zero_sweep(input string tag, input int n, input int l);
        start   = 1'b1;
        modulus = 3'(n);
        loops   = 4'(l);
        check({tag, ".busy_pre"}, int'(busy), 0);
        @(negedge clk);
        start = 1'b0;
        check({tag, ".busy"}, int'(busy), 0);
        check({tag, ".done"}, int'(done), 1);
        check({tag, ".tc"},   int'(tc),   0);
        @(negedge clk);
        check_all({tag, ".idle"}, 0, 0, 0, 0, 0);
        $display("zero sweep %s N=%0d L=%0d complete", tag, n, l);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b0;
        start    = 1'b0;
        stop     = 1'b0;
        modulus  = 3'd0;
        loops    = 4'd0;

        repeat (2) @(negedge clk);
        check_all("reset", 0, 0, 0, 0, 0);
        reset = 1'b1;
        @(negedge clk);
        check_all("post_reset", 0, 0, 0, 0, 0);
        $display("reset state checked");

        sweep("n5l2", 5, 2);
        sweep("n1l3", 1, 3);
        sweep("n7l2", 7, 2);
        sweep("n3l1", 3, 1);

        zero_sweep("n0l2", 0, 2);
        zero_sweep("n4l0", 4, 0);

        // Stop at d_out=2 in loop 0 of N=5,L=3
        start = 1'b1; modulus = 3'd5; loops = 4'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        check_all("stop.pre", 2, 0, 0, 1, 0);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        check_all("stop.post", 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_all($sformatf("stop.after[%0d]", i), 0, 0, 0, 0, 0);
        end
        $display("stop mid-sweep checked");

        // Stop coincident with the final wrap: no done pulse
        start = 1'b1; modulus = 3'd2; loops = 4'd1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check_all("stopwrap.pre", 1, 1, 0, 1, 0);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        check_all("stopwrap.post", 0, 0, 0, 0, 0);
        $display("stop on final wrap checked");

        // Stop alone in IDLE is ignored
        stop = 1'b1;
        @(negedge clk);
        check_all("stop_idle", 0, 0, 0, 0, 0);
        // start together with stop in IDLE starts the sweep
        start = 1'b1; modulus = 3'd3; loops = 4'd1;
        @(negedge clk);
        start = 1'b0;
        stop  = 1'b0;
        check_all("startstop[0]", 0, 0, 0, 1, 0);
        @(negedge clk);
        check_all("startstop[1]", 1, 0, 0, 1, 0);
        @(negedge clk);
        check_all("startstop[2]", 2, 1, 0, 1, 0);
        @(negedge clk);
        check_all("startstop.done", 0, 0, 1, 0, 1);
        @(negedge clk);
        $display("stop in IDLE and start+stop checked");

        // Asynchronous reset between edges mid-sweep (N=7, L=4)
        start = 1'b1; modulus = 3'd7; loops = 4'd4;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        check_all("rst.pre", 5, 0, 0, 1, 0);
        #2;
        reset = 1'b0;
        #1;
        check_all("rst.async", 0, 0, 0, 0, 0);
        @(negedge clk);
        check_all("rst.held", 0, 0, 0, 0, 0);
        reset = 1'b1;
        $display("async reset mid-sweep checked");
        sweep("rst_n3l1", 3, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
